// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: decoder-side bus of the multiply/divide unit
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, a, b, wr_hi, wr_lo, wdata,
                    input  busy, stall, done, hi, lo);
    modport slave  (input  start, op, a, b, wr_hi, wr_lo, wdata,
                    output busy, stall, done, hi, lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: one-bit-per-cycle unsigned MULTU/DIVU engine owning HI/LO
module muldiv_sequencer #(parameter int WIDTH = 32) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] p_q, p_d, p_nx;
    logic [WIDTH-1:0]   b_q, b_d, q_q, q_d, q_nx, r_q, r_d, r_nx;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH:0]     sum, t;
    logic               dz_q, dz_d, busy, accept, last, ge;

    assign busy   = state_q == MUL || state_q == DIV;
    assign accept = bus.start && !bus.op[1] && !busy;
    assign last   = count_q == CW'(WIDTH - 1);
    // Shift-add step: conditional add into the upper half keeps its carry, then shift right
    assign sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    assign p_nx   = {sum, p_q[WIDTH-1:1]};
    // Restoring step: the remainder stays below the divisor, so WIDTH bits hold it between steps
    assign t      = {r_q, q_q[WIDTH-1]};
    assign ge     = t >= {1'b0, b_q};
    assign r_nx   = WIDTH'(ge ? t - {1'b0, b_q} : t);
    assign q_nx   = {q_q[WIDTH-2:0], ge};

    assign bus.busy  = busy;
    assign bus.stall = busy || accept;
    assign bus.done  = state_q == DONE;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    // Next-state: accept/MTHI/MTLO when idle, otherwise advance the engine one bit
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        p_d     = p_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (!busy) begin
            state_d = IDLE;
            if (bus.wr_hi) hi_d = bus.wdata;
            if (bus.wr_lo) lo_d = bus.wdata;
            if (accept) begin
                state_d = bus.op[0] ? DIV : MUL;
                count_d = '0;
                p_d     = {{WIDTH{1'b0}}, bus.a};
                b_d     = bus.b;
                q_d     = bus.a;
                r_d     = '0;
                dz_d    = bus.op[0] && bus.b == '0;
            end
        end else begin
            count_d = count_q + 1'b1;
            if (state_q == MUL) begin
                p_d = p_nx;
                if (last) begin
                    hi_d    = p_nx[2*WIDTH-1:WIDTH];
                    lo_d    = p_nx[WIDTH-1:0];
                    state_d = DONE;
                end
            end else begin
                q_d = q_nx;
                r_d = r_nx;
                if (last || dz_q) begin
                    hi_d    = dz_q ? q_q : r_nx;
                    lo_d    = dz_q ? '1 : q_nx;
                    state_d = DONE;
                end
            end
        end
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            p_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            p_q     <= p_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for the multiply/divide sequencer
module tb_muldiv_sequencer;
    localparam int W = 32;
    typedef struct packed {logic [W-1:0] hi; logic [W-1:0] lo;} res_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   dones = 0;
    int   expected_dones = 0;
    res_t sb[$];
    res_t exp_res;

    muldiv_sequencer_if #(.WIDTH(W)) bus();
    muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding result
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            dones++;
            if (sb.size() == 0) check("spurious done", W'(dones), W'(expected_dones));
            else begin
                exp_res = sb.pop_front();
                check("result hi", bus.hi, exp_res.hi);
                check("result lo", bus.lo, exp_res.lo);
            end
        end
    end

    // Called at a negedge: drive start for one edge, record expected result
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input bit expect_done);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        if (expect_done) begin
            sb.push_back({eh, el});
            expected_dones++;
        end
        #1 check("stall on accept", W'(bus.stall), 1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Issue an op and follow it to done, checking latency, stall, HI/LO hold and an optional busy poke
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic [W-1:0] hh, input logic [W-1:0] hl,
                          input int lat, input bit poke);
        int n = 0;
        int stall_low = 0;
        issue(o, x, y, eh, el, 1'b1);
        do begin
            @(negedge clk);
            n++;
            if (poke && n == 11) begin
                bus.start = 1'b0;
                bus.wr_hi = 1'b0;
            end
            if (bus.done !== 1'b1 && bus.stall !== 1'b1) stall_low++;
            if (n == 16 && lat > 2) begin
                check("busy mid-op", W'(bus.busy), 1);
                check("hi held", bus.hi, hh);
                check("lo held", bus.lo, hl);
            end
            if (poke && n == 10) begin
                bus.start = 1'b1;
                bus.op    = 2'b01;
                bus.wr_hi = 1'b1;
                bus.wdata = 32'h5555;
            end
        end while (bus.done !== 1'b1 && n < 100);
        if (bus.done !== 1'b1) check("done timeout", W'(bus.done), 1);
        check("latency", W'(n), W'(lat));
        check("stall while busy", W'(stall_low), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        check("reset hi", bus.hi, 0);
        check("reset lo", bus.lo, 0);
        check("reset busy", W'(bus.busy), 0);
        check("reset stall", W'(bus.stall), 0);
        check("reset done", W'(bus.done), 0);
        reset = 1'b1;
        @(negedge clk);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0, 0, W + 1, 0);
        @(negedge clk);
        check("done one cycle", W'(bus.done), 0);
        check("stall after done", W'(bus.stall), 0);
        run_op(2'b01, 100, 7, 2, 14, 32'hFFFF_FFFE, 32'h1, W + 1, 0);
        @(negedge clk);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 2, 14, W + 1, 0);
        @(negedge clk);
        run_op(2'b01, 32'h1234, 0, 32'h1234, 32'hFFFF_FFFF, 0, 0, 2, 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        #1 check("reserved op stall", W'(bus.stall), 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'b00;
        check("reserved op busy", W'(bus.busy), 0);
        bus.wr_hi = 1'b1;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'hAAAA;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        check("mthi", bus.hi, 32'hAAAA);
        check("mtlo", bus.lo, 32'hAAAA);
        run_op(2'b00, 3, 5, 0, 15, 32'hAAAA, 32'hAAAA, W + 1, 1);
        @(negedge clk);
        issue(2'b01, 1000, 3, 0, 0, 1'b0);
        repeat (12) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async reset hi", bus.hi, 0);
        check("async reset lo", bus.lo, 0);
        check("async reset busy", W'(bus.busy), 0);
        check("async reset stall", W'(bus.stall), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("no done after reset", W'(dones), W'(expected_dones));
        run_op(2'b00, 6, 7, 0, 42, 0, 0, W + 1, 0);
        @(negedge clk);
        run_op(2'b01, 9, 2, 1, 4, 0, 42, W + 1, 0);
        run_op(2'b00, 2, 3, 0, 6, 1, 4, W + 1, 0);
        repeat (3) @(negedge clk);
        check("done count", W'(dones), W'(expected_dones));
        check("scoreboard empty", W'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
